// File: rtl/im_loader_pkg.sv
// rtl/im_loader_pkg.sv - shared state encoding and constants for the instruction-memory loader
// Contents:
//   state_t            loader FSM states, 3-bit encoding
//   SYNC_BYTE_DEFAULT  default frame start marker
//   BYTE_IDX_W         width of the byte-within-word index
package im_loader_pkg;

  localparam int         BYTE_IDX_W        = 2;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_HI = 3'd1,
    ST_CNT_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

endpackage

// File: rtl/im_loader_word_assembler.sv
// rtl/im_loader_word_assembler.sv - 8-to-32 big-endian word assembler
// Ports:
//   CLK, RST_F  clock, asynchronous active-low reset
//   clr         synchronous clear of index and partial word
//   start       restart at byte 0 (new frame)
//   shift       accept data_byte into the word
//   data_byte   incoming byte
//   word        assembled word including the byte currently presented
//   complete    high when the byte being shifted is the 4th of a word
module im_loader_word_assembler
  import im_loader_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_F,
  input  logic        clr,
  input  logic        start,
  input  logic        shift,
  input  logic [7:0]  data_byte,
  output logic [31:0] word,
  output logic        complete
);

  logic [BYTE_IDX_W-1:0] idx;
  logic [23:0]           shreg;

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      idx   <= '0;
      shreg <= '0;
    end else if (clr || start) begin
      idx   <= '0;
      shreg <= '0;
    end else if (shift) begin
      shreg <= {shreg[15:0], data_byte};
      idx   <= idx + 1'b1;  // wraps 3 -> 0 at the end of a word
    end
  end

  // The 4th byte is combined directly so the full word is available in the
  // same cycle it is accepted, letting the write register capture it.
  assign word     = {shreg, data_byte};
  assign complete = shift && (&idx);

endmodule

// File: rtl/im_loader.sv
// rtl/im_loader.sv - boot-time framed byte-stream writer for instruction memory
// Ports:
//   CLK, RST_F          clock, asynchronous active-low reset
//   clr                 synchronous clear to IDLE (processor stays held)
//   in_data/in_valid    byte stream input
//   in_ready            byte accepted when in_valid && in_ready
//   im_we/im_addr/im_wdata  instruction memory write port
//   cpu_rst_f           active-low processor reset, released only in DONE
//   busy/done/err       status
module im_loader
  import im_loader_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] LOAD_BASE = '0,
  parameter logic [7:0]        SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST_F,
  input  logic              clr,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst_f,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state, next_state;
  logic              xfer;
  logic [15:0]       cnt;       // words remaining in the current frame
  logic [7:0]        csum;
  logic [ADDR_W-1:0] waddr;     // address the next completed word goes to
  logic [31:0]       word;
  logic              complete;
  logic              asm_start;
  logic              asm_shift;

  assign xfer      = in_valid && in_ready;
  assign asm_start = xfer && (state == ST_CNT_LO);
  assign asm_shift = xfer && (state == ST_DATA) && !clr;

  im_loader_word_assembler u_asm (
    .CLK       (CLK),
    .RST_F     (RST_F),
    .clr       (clr),
    .start     (asm_start),
    .shift     (asm_shift),
    .data_byte (in_data),
    .word      (word),
    .complete  (complete)
  );

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (clr) begin
      next_state = ST_IDLE;
    end else if (xfer) begin
      case (state)
        ST_IDLE:   if (in_data == SYNC_BYTE) next_state = ST_CNT_HI;
        ST_CNT_HI: next_state = ST_CNT_LO;
        ST_CNT_LO: next_state = ({cnt[15:8], in_data} == 16'd0) ? ST_CSUM : ST_DATA;
        ST_DATA:   if (complete && (cnt == 16'd1)) next_state = ST_CSUM;
        ST_CSUM:   next_state = (in_data == csum) ? ST_DONE : ST_ERR;
        ST_DONE:   if (in_data == SYNC_BYTE) next_state = ST_CNT_HI;
        ST_ERR:    next_state = ST_ERR;
        default:   next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      cnt      <= '0;
      csum     <= '0;
      waddr    <= LOAD_BASE;
      im_we    <= 1'b0;
      im_addr  <= LOAD_BASE;
      im_wdata <= '0;
    end else begin
      im_we <= 1'b0;
      if (clr) begin
        cnt   <= '0;
        csum  <= '0;
        waddr <= LOAD_BASE;
      end else if (xfer) begin
        case (state)
          ST_CNT_HI: cnt[15:8] <= in_data;
          ST_CNT_LO: begin
            cnt   <= {cnt[15:8], in_data};
            csum  <= '0;
            waddr <= LOAD_BASE;
          end
          ST_DATA: begin
            csum <= csum ^ in_data;
            if (complete) begin
              im_we    <= 1'b1;
              im_wdata <= word;
              im_addr  <= waddr;
              waddr    <= waddr + ADDR_W'(1);  // wraps modulo 2^ADDR_W
              cnt      <= cnt - 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Status derives from the registered state, so done/cpu_rst_f rise the
  // cycle after the checksum byte and fall the cycle after a reload sync.
  assign in_ready  = (state != ST_ERR);
  assign busy      = (state == ST_CNT_HI) || (state == ST_CNT_LO) ||
                     (state == ST_DATA)   || (state == ST_CSUM);
  assign done      = (state == ST_DONE);
  assign cpu_rst_f = (state == ST_DONE);
  assign err       = (state == ST_ERR);

endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - self-checking bench for im_loader with a frame-level reference model
module tb_im_loader;

  logic        CLK = 1'b0;
  logic        RST_F = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;

  logic        a_ready, a_we, a_crst, a_busy, a_done, a_err;
  logic [15:0] a_addr;
  logic [31:0] a_wdata;
  logic        w_ready, w_we, w_crst, w_busy, w_done, w_err;
  logic [15:0] w_addr;
  logic [31:0] w_wdata;

  im_loader #(.ADDR_W(16), .LOAD_BASE(16'h0000), .SYNC_BYTE(8'hA5)) u_dut (
    .CLK(CLK), .RST_F(RST_F), .clr(clr), .in_data(in_data), .in_valid(in_valid),
    .in_ready(a_ready), .im_we(a_we), .im_addr(a_addr), .im_wdata(a_wdata),
    .cpu_rst_f(a_crst), .busy(a_busy), .done(a_done), .err(a_err)
  );

  im_loader #(.ADDR_W(16), .LOAD_BASE(16'hFFFF), .SYNC_BYTE(8'hA5)) u_wrap (
    .CLK(CLK), .RST_F(RST_F), .clr(clr), .in_data(in_data), .in_valid(in_valid),
    .in_ready(w_ready), .im_we(w_we), .im_addr(w_addr), .im_wdata(w_wdata),
    .cpu_rst_f(w_crst), .busy(w_busy), .done(w_done), .err(w_err)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  bit gap_mode = 1'b0;

  logic [47:0] wq_a[$];
  logic [47:0] wq_w[$];
  longint      wt_a[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write-port monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (a_we) begin
      wq_a.push_back({a_addr, a_wdata});
      wt_a.push_back($time);
    end
    if (w_we) wq_w.push_back({w_addr, w_wdata});
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    @(negedge CLK);
    if (gap_mode) begin
      int g;
      g = $urandom_range(0, 3);
      for (int k = 0; k < g; k++) begin
        in_valid = 1'b0;
        @(negedge CLK);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!a_ready && t < 8) begin
      @(negedge CLK);
      t++;
    end
    check("in_ready_before_byte", 64'(a_ready), 64'(1));
    @(posedge CLK);
    #1 in_valid = 1'b0;
  endtask

  task automatic check_idle_like(input string tag);
    check({tag, "_err"},      64'(a_err),   64'(0));
    check({tag, "_in_ready"}, 64'(a_ready), 64'(1));
    check({tag, "_busy"},     64'(a_busy),  64'(0));
    check({tag, "_cpu_rst"},  64'(a_crst),  64'(0));
  endtask

  // Sends garbage, then one frame built from words; checksum is the XOR of
  // all data bytes, optionally xor-ed with csum_mask to corrupt it.
  task automatic do_frame(input logic [31:0] words[$], input logic [7:0] garb[$],
                          input logic [7:0] csum_mask, input string tag);
    logic [7:0]  x;
    logic [7:0]  b;
    logic [15:0] n;
    bit          good;
    x = 8'h00;
    n = 16'(words.size());
    good = (csum_mask == 8'h00);
    wq_a.delete(); wq_w.delete(); wt_a.delete();
    foreach (garb[i]) send_byte(garb[i]);
    send_byte(8'hA5);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    foreach (words[i]) begin
      for (int k = 0; k < 4; k++) begin
        b = words[i][31 - 8*k -: 8];
        x ^= b;
        send_byte(b);
      end
    end
    send_byte(x ^ csum_mask);
    @(negedge CLK);
    check({tag, "_done"},     64'(a_done),  64'(good));
    check({tag, "_cpu_rst"},  64'(a_crst),  64'(good));
    check({tag, "_err"},      64'(a_err),   64'(!good));
    check({tag, "_in_ready"}, 64'(a_ready), 64'(good));
    check({tag, "_busy"},     64'(a_busy),  64'(0));
    check({tag, "_wrap_done"}, 64'(w_done), 64'(good));
    check({tag, "_nwrites"},      64'(wq_a.size()), 64'(words.size()));
    check({tag, "_wrap_nwrites"}, 64'(wq_w.size()), 64'(words.size()));
    foreach (words[i]) begin
      if (i < wq_a.size())
        check({tag, "_write"}, 64'(wq_a[i]), 64'({16'(i), words[i]}));
      if (i < wq_w.size())
        check({tag, "_wrap_write"}, 64'(wq_w[i]), 64'({16'(32'hFFFF + i), words[i]}));
    end
    if (!good) begin
      clr = 1'b1;
      @(negedge CLK);
      clr = 1'b0;
      check_idle_like({tag, "_after_clr"});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] wv[$];
    logic [7:0]  gv[$];
    logic [7:0]  x;

    // Reset values.
    repeat (3) @(negedge CLK);
    check("rst_we",    64'(a_we),    64'(0));
    check("rst_addr",  64'(a_addr),  64'(16'h0000));
    check("rst_wdata", 64'(a_wdata), 64'(0));
    check("rst_done",  64'(a_done),  64'(0));
    check("rst_wrap_addr", 64'(w_addr), 64'(16'hFFFF));
    check_idle_like("rst");
    RST_F = 1'b1;

    // Scenario 1: fixed two-word frame, back-to-back bytes.
    wv = {32'h12345678, 32'h9ABCDEF0};
    gv.delete();
    do_frame(wv, gv, 8'h00, "s1");
    if (wt_a.size() == 2) check("s1_write_spacing", 64'(wt_a[1] - wt_a[0]), 64'(40));

    // Reload from DONE: processor held again the cycle after the sync byte.
    send_byte(8'hA5);
    @(negedge CLK);
    check("reload_cpu_rst", 64'(a_crst), 64'(0));
    check("reload_done",    64'(a_done), 64'(0));
    check("reload_busy",    64'(a_busy), 64'(1));
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    @(negedge CLK);
    check("reload_n0_done", 64'(a_done), 64'(1));

    // Scenario 2: the eight data bytes XOR to 0x00, so 0x88 is a bad checksum.
    do_frame(wv, gv, 8'h88, "s2");

    // Scenario 3: garbage before an empty frame.
    gv = {8'h00, 8'hFF, 8'h11};
    wv.delete();
    do_frame(wv, gv, 8'h00, "s3");

    // Scenario 4: scenario 1 frame with random valid gaps.
    gap_mode = 1'b1;
    wv = {32'h12345678, 32'h9ABCDEF0};
    gv.delete();
    do_frame(wv, gv, 8'h00, "s4");

    // Randomized frames.
    for (int it = 0; it < 20; it++) begin
      int n, ng;
      gap_mode = ($urandom_range(0, 1) == 1);
      n = $urandom_range(0, 5);
      ng = $urandom_range(0, 3);
      wv.delete(); gv.delete();
      for (int i = 0; i < n; i++) wv.push_back($urandom);
      for (int i = 0; i < ng; i++) begin
        logic [7:0] g;
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h5A;
        gv.push_back(g);
      end
      do_frame(wv, gv, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, "rnd");
    end

    // Scenario 6: asynchronous reset in the middle of DATA.
    gap_mode = 1'b0;
    wq_a.delete(); wq_w.delete();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    send_byte(8'h01); send_byte(8'h02);
    @(negedge CLK);
    check("mid_nwrites", 64'(wq_a.size()), 64'(1));
    if (wq_a.size() == 1) check("mid_write", 64'(wq_a[0]), 64'({16'h0000, 32'hDEADBEEF}));
    #2 RST_F = 1'b0;
    #1;
    check("arst_we",    64'(a_we),    64'(0));
    check("arst_addr",  64'(a_addr),  64'(16'h0000));
    check("arst_wdata", 64'(a_wdata), 64'(0));
    check("arst_done",  64'(a_done),  64'(0));
    check_idle_like("arst");
    @(negedge CLK);
    RST_F = 1'b1;
    wv = {32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF};
    gv.delete();
    do_frame(wv, gv, 8'h00, "s6");

    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
